uwasic_onboarding_ayoung_eun: RTL and testbench
===============================================

// Module: uwasic_onboarding_ayoung_eun
// PURPOSE
//  Tiny Tapeout user tile: SPI-writable register bank driving 16 outputs, each optionally PWM-modulated.
//  An external SPI controller (mode 0, write-only) programs output enables, PWM enables and one shared 8-bit duty.
//  Outputs map to uo_out[7:0] and uio_out[7:0]; all uio pins are permanently outputs.
// PARAMETERS
//  PRESCALE  13  clk cycles per PWM counter step (10 MHz clk -> 256*13 = 3328 cycles, ~3.0 kHz PWM)
//  MAX_ADDR  4   highest implemented register address
// PORTS
//  clk      in   1  system clock (10 MHz nominal); the only clock
//  rst_n    in   1  reset: synchronous, active-high (1 = reset) -- port keeps tile-standard name
//  ena      in   1  tile enable; ignored (design always active)
//  ui_in    in   8  [0]=SCLK, [1]=COPI, [2]=nCS (active low); [7:3] unused
//  uio_in   in   8  unused
//  uo_out   out  8  out[7:0]
//  uio_out  out  8  out[15:8]
//  uio_oe   out  8  constant 8'hFF
// BEHAVIOUR
//  Register map (8-bit each, reset 0x00):
//   0x00 en_out[7:0]; 0x01 en_out[15:8]; 0x02 en_pwm[7:0]; 0x03 en_pwm[15:8]; 0x04 duty.
//  SPI input: SCLK, COPI, nCS each through a 2-FF synchronizer into clk.
//   SCLK rising edge detected on synchronized samples.
//  Frame: nCS falling resets bit count and shift reg.
//   While nCS low, each SCLK rise shifts COPI in, MSB first.
//   Frame = 16 bits: [15]=R/W (1=write), [14:8]=addr, [7:0]=data.
//   Bits beyond 16 are ignored; bit count saturates at 16.
//  Commit on nCS rising edge (synchronized), effective the next clk:
//   only if exactly 16 bits were received, R/W=1 and addr<=MAX_ADDR.
//   Otherwise discard: no state change for reads, bad addresses, short frames.
//   No read-back path; there is no COPI->CIPO output.
//  SCLK must be <= clk/4 so the synchronizers see every edge.
//  PWM: prescaler counts 0..PRESCALE-1; on wrap an 8-bit pwm_cnt increments, wrapping 255->0.
//   pwm_sig = (duty==8'hFF) ? 1 : (pwm_cnt < duty).
//   duty 0 => constantly low; 0xFF => constantly high; else high for duty/256 of the period.
//  Per bit i in 0..15:
//   out[i] = en_out[i] ? (en_pwm[i] ? pwm_sig : 1) : 0.
//   en_pwm without en_out gives 0.
//  Outputs are registered or decoded from registers only; no combinational path from ui_in.
//  Reset (rst_n=1 at clk rise): registers, counters, synchronizers and SPI state clear.
//   uo_out=0, uio_out=0, uio_oe=FF.
//   Reset during a frame aborts it with no write.
//  Back-to-back frames are supported with nCS high >= 4 clk between them.
// TESTING
//  1 Reset: rst_n=1 for 5 clk -> uo_out=00, uio_out=00, uio_oe=FF.
//  2 Write 0x8000F0 (addr0=F0) then 0x8101CC -> uo_out=F0, uio_out=CC.
//    Read frame 0x0000_30 -> no change.
//  3 Write addr 0x05 or 0x7F with data FF -> no register changes.
//    12-bit frame aborted by nCS -> ignored.
//  4 en_out[0]=1, en_pwm[0]=1, duty=0x80 -> uo_out[0] period 3328 clk, high 1664 clk (50%).
//  5 Same setup with duty=0x00 -> uo_out[0] constant 0.
//    duty=0xFF -> constant 1 over >= 2 periods.
//  6 Mid-frame reset: assert rst_n after 8 SCLKs, then complete frame -> no write.
//    Next full write succeeds.

Source files
------------

// File: rtl/uwasic_onboarding_ayoung_eun.sv
// SPI-writable register bank driving 16 outputs, each optionally gated by a shared PWM.
// Write-only SPI mode 0 slave sampled in the clk domain; no read-back path.
module uwasic_onboarding_ayoung_eun #(
    parameter int PRESCALE = 13,
    parameter int MAX_ADDR = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int            PW            = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESCALE_LAST = PW'(PRESCALE - 1);
    localparam logic [6:0]    MAX_ADDR_L    = 7'(MAX_ADDR);
    localparam logic [4:0]    FRAME_BITS    = 5'd16;

    // NOTE: the tile-standard port name hides an active-high synchronous reset.
    logic rst;
    assign rst = rst_n;

    logic unused_inputs;
    assign unused_inputs = &{1'b0, ena, uio_in, ui_in[7:3]};

    // ---------------------------------------------------------------- synchronizers
    logic [2:0] sync1;
    logic [2:0] sync2;
    logic       sclk_prev;
    logic       ncs_prev;

    // NOTE: non-blocking assignments make each flop take the previous stage's old value.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1     <= '0;
            sync2     <= '0;
            sclk_prev <= 1'b0;
            ncs_prev  <= 1'b0;
        end else begin
            sync1     <= ui_in[2:0];
            sync2     <= sync1;
            sclk_prev <= sync2[0];
            ncs_prev  <= sync2[2];
        end
    end

    logic sclk_rise;
    logic ncs_fall;
    logic ncs_rise;
    logic copi;

    assign sclk_rise = sync2[0] & ~sclk_prev;
    assign ncs_fall  = ~sync2[2] & ncs_prev;
    assign ncs_rise  = sync2[2] & ~ncs_prev;
    assign copi      = sync2[1];

    // ---------------------------------------------------------------- frame receiver
    // A frame only counts once its nCS falling edge was seen, so a reset mid-frame aborts it.
    logic        active;
    logic [4:0]  bit_cnt;
    logic [15:0] shift_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            active    <= 1'b0;
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else if (ncs_fall) begin
            active    <= 1'b1;
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else if (ncs_rise) begin
            active    <= 1'b0;
        end else if (active && !sync2[2] && sclk_rise && bit_cnt != FRAME_BITS) begin
            shift_reg <= {shift_reg[14:0], copi};
            bit_cnt   <= bit_cnt + 5'd1;
        end
    end

    logic       wr_en;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;

    assign wr_addr = shift_reg[14:8];
    assign wr_data = shift_reg[7:0];
    assign wr_en   = ncs_rise && active && (bit_cnt == FRAME_BITS)
                     && shift_reg[15] && (wr_addr <= MAX_ADDR_L);

    // ---------------------------------------------------------------- register bank
    logic [15:0] en_out;
    logic [15:0] en_pwm;
    logic [7:0]  duty;

    // NOTE: the bank is a handful of flops, so every entry is reset rather than left undefined.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_out <= '0;
            en_pwm <= '0;
            duty   <= '0;
        end else if (wr_en) begin
            case (wr_addr)
                7'd0:    en_out[7:0]  <= wr_data;
                7'd1:    en_out[15:8] <= wr_data;
                7'd2:    en_pwm[7:0]  <= wr_data;
                7'd3:    en_pwm[15:8] <= wr_data;
                7'd4:    duty         <= wr_data;
                default: ;
            endcase
        end
    end

    // ---------------------------------------------------------------- PWM
    logic [PW-1:0] presc;
    logic [7:0]    pwm_cnt;
    logic          pwm_sig;

    always_ff @(posedge clk) begin
        if (rst) begin
            presc   <= '0;
            pwm_cnt <= '0;
        end else if (presc == PRESCALE_LAST) begin
            presc   <= '0;
            pwm_cnt <= pwm_cnt + 8'd1;
        end else begin
            presc   <= presc + PW'(1);
        end
    end

    // Full-scale duty must stay high through pwm_cnt == 255.
    assign pwm_sig = (duty == 8'hFF) ? 1'b1 : (pwm_cnt < duty);

    // ---------------------------------------------------------------- outputs
    logic [15:0] out_bits;

    assign out_bits = en_out & (~en_pwm | {16{pwm_sig}});
    assign uo_out   = out_bits[7:0];
    assign uio_out  = out_bits[15:8];
    assign uio_oe   = 8'hFF;

endmodule

// File: tb/tb_uwasic_onboarding_ayoung_eun.sv
// Self-checking bench: bit-banged SPI frames, a register model feeding an expected-output
// queue, and cycle-counted PWM measurements.
`timescale 1ns/1ps
module tb_uwasic_onboarding_ayoung_eun;

    localparam int PRESCALE = 13;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       sclk;
    logic       copi;
    logic       ncs;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    assign ui_in = {5'b0, ncs, copi, sclk};

    uwasic_onboarding_ayoung_eun dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #50 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  m_regs [0:4];
    logic [15:0] exp_q [$];
    int          pwm_q [$];

    task automatic clk_wait(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 5; i++) m_regs[i] = 8'h00;
    endtask

    function automatic logic [15:0] model_out(input logic pwm);
        logic [15:0] eo;
        logic [15:0] ep;
        eo = {m_regs[1], m_regs[0]};
        ep = {m_regs[3], m_regs[2]};
        return eo & (~ep | {16{pwm}});
    endfunction

    // Apply a frame to the model and, when the output is deterministic, push the expectation.
    task automatic model_frame(input logic [31:0] bits, input int n);
        logic [15:0] f;
        if (n >= 16) begin
            f = bits[n-1 -: 16];
            if (f[15] && f[14:8] <= 7'd4) m_regs[f[10:8]] = f[7:0];
        end
        if (m_regs[4] == 8'h00 || m_regs[4] == 8'hFF)
            exp_q.push_back(model_out(m_regs[4] == 8'hFF));
    endtask

    task automatic send_bits(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            copi = bits[i];
            clk_wait(4);
            sclk = 1'b1;
            clk_wait(4);
            sclk = 1'b0;
        end
    endtask

    task automatic spi_frame(input logic [31:0] bits, input int n);
        ncs = 1'b0;
        clk_wait(4);
        send_bits(bits, n);
        clk_wait(4);
        ncs = 1'b1;
        model_frame(bits, n);
        clk_wait(8);
    endtask

    task automatic sb_drain(input string name);
        logic [15:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if ({uio_out, uo_out} !== e) begin
                n_fail++;
                $display("FAIL %s: outputs=%h expected=%h", name, {uio_out, uo_out}, e);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1; ena = 1'b1; uio_in = 8'h00;
        sclk = 1'b0; copi = 1'b0; ncs = 1'b1;
        model_reset();
        clk_wait(5);
        n_checks++;
        if (uo_out !== 8'h00) begin n_fail++; $display("FAIL reset_uo: got=%h expected=00", uo_out); end
        n_checks++;
        if (uio_out !== 8'h00) begin n_fail++; $display("FAIL reset_uio: got=%h expected=00", uio_out); end
        n_checks++;
        if (uio_oe !== 8'hFF) begin n_fail++; $display("FAIL reset_oe: got=%h expected=FF", uio_oe); end
        rst_n = 1'b0;
        clk_wait(6);
        exp_q.push_back(model_out(1'b0));
        sb_drain("post_reset");
    endtask

    task automatic test_write();
        spi_frame(32'h80F0, 16); sb_drain("write_addr0");
        spi_frame(32'h81CC, 16); sb_drain("write_addr1");
        spi_frame(32'h0030, 16); sb_drain("read_ignored");
        n_checks++;
        if (uio_oe !== 8'hFF) begin n_fail++; $display("FAIL oe_const: got=%h expected=FF", uio_oe); end
    endtask

    task automatic test_bad_frames();
        spi_frame(32'h85FF, 16);  sb_drain("addr5_ignored");
        spi_frame(32'hFFFF, 16);  sb_drain("addr7f_ignored");
        spi_frame(32'h82F,  12);  sb_drain("short_frame");
        spi_frame(32'h8055A, 20); sb_drain("long_frame");
    endtask

    task automatic test_pwm_50();
        int high;
        int low;
        int b;
        int exp_h;
        int exp_l;
        spi_frame(32'h8001, 16); sb_drain("pwm_en_out0");
        spi_frame(32'h8100, 16); sb_drain("pwm_en_out1");
        spi_frame(32'h8201, 16); sb_drain("pwm_en_pwm0");
        spi_frame(32'h8480, 16);
        pwm_q.push_back(int'(m_regs[4]) * PRESCALE);
        pwm_q.push_back((256 - int'(m_regs[4])) * PRESCALE);
        b = 0;
        while (uo_out[0] !== 1'b0 && b < 4000) begin clk_wait(1); b++; end
        while (uo_out[0] !== 1'b1 && b < 8000) begin clk_wait(1); b++; end
        high = 0;
        while (uo_out[0] === 1'b1 && high < 4000) begin clk_wait(1); high++; end
        low = 0;
        while (uo_out[0] === 1'b0 && low < 4000) begin clk_wait(1); low++; end
        exp_h = pwm_q.pop_front();
        exp_l = pwm_q.pop_front();
        n_checks++;
        if (high != exp_h) begin n_fail++; $display("FAIL pwm50_high: cycles=%0d expected=%0d", high, exp_h); end
        n_checks++;
        if (low != exp_l) begin n_fail++; $display("FAIL pwm50_low: cycles=%0d expected=%0d", low, exp_l); end
    endtask

    task automatic monitor_const(input string name, input int cycles);
        logic [15:0] e;
        int bad;
        e = exp_q.pop_front();
        bad = 0;
        for (int i = 0; i < cycles; i++) begin
            clk_wait(1);
            if ({uio_out, uo_out} !== e) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL %s: %0d cycles differed from expected=%h (last=%h)", name, bad, e, {uio_out, uo_out});
        end
    endtask

    task automatic test_pwm_const();
        spi_frame(32'h8203, 16);
        spi_frame(32'h8180, 16);
        spi_frame(32'h8400, 16);
        while (exp_q.size() > 1) void'(exp_q.pop_front());
        exp_q.push_back(exp_q[0]);
        sb_drain("duty00_settled");
        exp_q.push_back(model_out(1'b0));
        monitor_const("duty00_const", 7000);
        spi_frame(32'h84FF, 16);
        exp_q.push_back(exp_q[0]);
        sb_drain("dutyff_settled");
        exp_q.push_back(model_out(1'b1));
        monitor_const("dutyff_const", 7000);
    endtask

    task automatic test_mid_reset();
        ncs = 1'b0;
        clk_wait(4);
        send_bits(32'h81, 8);
        rst_n = 1'b1;
        clk_wait(3);
        rst_n = 1'b0;
        model_reset();
        send_bits(32'hFF, 8);
        clk_wait(4);
        ncs = 1'b1;
        clk_wait(8);
        exp_q.push_back(model_out(1'b0));
        sb_drain("mid_reset_no_write");
        spi_frame(32'h81FF, 16); sb_drain("after_reset_write");
    endtask

    initial begin
        test_reset();
        test_write();
        test_bad_frames();
        test_pwm_50();
        test_pwm_const();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
